// File: rtl/modport_switch.sv
// Two-input, two-output packet switch: per-input FIFOs, DA-based routing and
// per-output round-robin arbitration that only switches at packet boundaries.
module modport_switch #(
  parameter logic [31:0] PORTA_ADDR   = 32'h0000_ABCD,
  parameter logic [31:0] PORTB_ADDR   = 32'h0000_BEEF,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          STALL_THRESH = 12
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] inDataA,
  input  logic        inSopA,
  input  logic        inEopA,
  input  logic [31:0] inDataB,
  input  logic        inSopB,
  input  logic        inEopB,
  output logic [31:0] outDataA,
  output logic        outSopA,
  output logic        outEopA,
  output logic [31:0] outDataB,
  output logic        outSopB,
  output logic        outEopB,
  output logic        portAStall,
  output logic        portBStall,
  output logic [5:0]  dbgState
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(STALL_THRESH);

  // Index 0 is port/input A, index 1 is port/input B throughout.
  logic [31:0] inData [2];
  logic [1:0]  inSop, inEop;

  logic [33:0] mem [2][FIFO_DEPTH];
  logic [33:0] head [2];
  logic [AW:0] wp [2];
  logic [AW:0] rp [2];
  logic [AW:0] cnt [2];
  logic [AW:0] cntNext [2];

  logic [1:0]  inPkt, drain, stall;
  logic [1:0]  wr, rd, wSop, empty, full, owned;
  logic [1:0]  headSop, headEop, toA, toB, badHead;
  logic [31:0] headData [2];
  logic [1:0]  req [2];

  logic [1:0]  busy, own, rr, active, rel, free;
  logic [31:0] outData [2];
  logic [1:0]  outSop, outEop;

  assign inData[0] = inDataA;
  assign inData[1] = inDataB;
  assign inSop     = {inSopB, inSopA};
  assign inEop     = {inEopB, inEopA};

  always_comb begin
    wr = '0;
    rd = '0;
    wSop = '0;
    empty = '0;
    full = '0;
    owned = '0;
    headSop = '0;
    headEop = '0;
    toA = '0;
    toB = '0;
    badHead = '0;
    for (int p = 0; p < 2; p++) begin
      head[p]     = mem[p][rp[p][AW-1:0]];
      headData[p] = head[p][31:0];
      headSop[p]  = head[p][33];
      headEop[p]  = head[p][32];
      cnt[p]      = wp[p] - rp[p];
      empty[p]    = (cnt[p] == '0);
      full[p]     = (cnt[p] == DEPTH_C);
      // A word is only accepted as a packet start or inside an open packet.
      wr[p]       = (inSop[p] | inPkt[p]) & ~full[p];
      wSop[p]     = inSop[p] & ~inPkt[p];
      toA[p]      = (headData[p] == PORTA_ADDR);
      toB[p]      = (headData[p] == PORTB_ADDR);
      owned[p]    = (busy[0] && own[0] == 1'(p)) || (busy[1] && own[1] == 1'(p));
      badHead[p]  = ~empty[p] & headSop[p] & ~toA[p] & ~toB[p] & ~owned[p];
      rd[p]       = ~empty[p] & (owned[p] | drain[p] | badHead[p]);
      cntNext[p]  = cnt[p] + (AW+1)'(wr[p]) - (AW+1)'(rd[p]);
    end
    for (int o = 0; o < 2; o++) begin
      for (int p = 0; p < 2; p++) begin
        req[o][p] = ~empty[p] & headSop[p] & ~owned[p] & ~drain[p] &
                    ((o == 0) ? toA[p] : toB[p]);
      end
    end
  end

  always_comb begin
    active = '0;
    rel = '0;
    free = '0;
    for (int o = 0; o < 2; o++) begin
      active[o] = busy[o] & ~empty[own[o]];
      rel[o]    = active[o] & headEop[own[o]];
      // An output can be re-granted in the same cycle its EOP leaves.
      free[o]   = ~busy[o] | rel[o];
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wr[p]) mem[p][wp[p][AW-1:0]] <= {wSop[p], inEop[p], inData[p]};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int p = 0; p < 2; p++) begin
        wp[p] <= '0;
        rp[p] <= '0;
      end
      inPkt <= '0;
      drain <= '0;
      stall <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr[p]) wp[p] <= wp[p] + 1'b1;
        if (rd[p]) rp[p] <= rp[p] + 1'b1;
        if (inSop[p] | inPkt[p]) inPkt[p] <= ~inEop[p];
        if (rd[p] && !owned[p]) drain[p] <= ~headEop[p];
        stall[p] <= (cntNext[p] >= THRESH_C);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busy   <= '0;
      own    <= '0;
      rr     <= '0;
      outSop <= '0;
      outEop <= '0;
      for (int o = 0; o < 2; o++) outData[o] <= '0;
    end else begin
      for (int o = 0; o < 2; o++) begin
        if (free[o]) begin
          if (req[o][0] && req[o][1]) begin
            busy[o] <= 1'b1;
            own[o]  <= rr[o];
            rr[o]   <= ~rr[o];
          end else if (req[o][0]) begin
            busy[o] <= 1'b1;
            own[o]  <= 1'b0;
          end else if (req[o][1]) begin
            busy[o] <= 1'b1;
            own[o]  <= 1'b1;
          end else begin
            busy[o] <= 1'b0;
          end
        end
        outData[o] <= active[o] ? headData[own[o]] : '0;
        outSop[o]  <= active[o] & headSop[own[o]];
        outEop[o]  <= active[o] & headEop[own[o]];
      end
    end
  end

  assign outDataA   = outData[0];
  assign outSopA    = outSop[0];
  assign outEopA    = outEop[0];
  assign outDataB   = outData[1];
  assign outSopB    = outSop[1];
  assign outEopB    = outEop[1];
  assign portAStall = stall[0];
  assign portBStall = stall[1];
  assign dbgState   = {busy, own, drain};

endmodule

// File: tb/tb_modport_switch.sv
// Directed bench for modport_switch: expected words are queued per output at
// issue time and a negedge monitor pops and compares every output word.
module tb_modport_switch;
  localparam logic [31:0] DA_A = 32'h0000_ABCD;
  localparam logic [31:0] DA_B = 32'h0000_BEEF;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] inDataA, inDataB;
  logic        inSopA, inEopA, inSopB, inEopB;
  logic [31:0] outDataA, outDataB;
  logic        outSopA, outEopA, outSopB, outEopB;
  logic        portAStall, portBStall;
  logic [5:0]  dbgState;

  logic [33:0] expA_q[$];
  logic [33:0] expB_q[$];
  logic [31:0] pktA [32];
  logic [31:0] pktB [32];
  bit          rrMod [2];
  int nVec = 0, nFail = 0, cyc = 0;
  int sopCycA = -1, sopCycB = -1, sentA = -1, sentB = -1, midSopA = -1;

  always #5 clk = ~clk;

  modport_switch dut (
    .clk(clk), .resetN(resetN),
    .inDataA(inDataA), .inSopA(inSopA), .inEopA(inEopA),
    .inDataB(inDataB), .inSopB(inSopB), .inEopB(inEopB),
    .outDataA(outDataA), .outSopA(outSopA), .outEopA(outEopA),
    .outDataB(outDataB), .outSopB(outSopB), .outEopB(outEopB),
    .portAStall(portAStall), .portBStall(portBStall), .dbgState(dbgState)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every non-idle output word must match the head of its queue.
  always @(negedge clk) begin
    if (resetN) begin
      if (outSopA || outEopA || outDataA != 0) begin
        if (outSopA) sopCycA = cyc;
        if (expA_q.size() == 0) chk("outA_unexpected", {30'd0, outSopA, outEopA, outDataA}, 64'd0);
        else chk("outA_word", {30'd0, outSopA, outEopA, outDataA}, {30'd0, expA_q.pop_front()});
      end
      if (outSopB || outEopB || outDataB != 0) begin
        if (outSopB) sopCycB = cyc;
        if (expB_q.size() == 0) chk("outB_unexpected", {30'd0, outSopB, outEopB, outDataB}, 64'd0);
        else chk("outB_word", {30'd0, outSopB, outEopB, outDataB}, {30'd0, expB_q.pop_front()});
      end
    end
  end

  function automatic int route(input logic [31:0] da);
    if (da == DA_A) return 0;
    if (da == DA_B) return 1;
    return -1;
  endfunction

  task automatic pushPkt(input bit fromB, input int n, input int dst);
    logic [31:0] w;
    bit s, e;
    for (int i = 0; i < n; i++) begin
      w = fromB ? pktB[i] : pktA[i];
      s = (i == 0);
      e = (i == n - 1);
      if (dst == 0) expA_q.push_back({s, e, w});
      else expB_q.push_back({s, e, w});
    end
  endtask

  task automatic zeroInputs();
    inDataA = '0; inSopA = 1'b0; inEopA = 1'b0;
    inDataB = '0; inSopB = 1'b0; inEopB = 1'b0;
  endtask

  // Drives packet A (na words, starting at cycle sa) and packet B alongside.
  task automatic drive2(input int na, input int nb, input int sa, input int sb);
    int oA, oB, last, k;
    bit bFirst;
    oA = (na > 0) ? route(pktA[0]) : -1;
    oB = (nb > 0) ? route(pktB[0]) : -1;
    if (oA >= 0 && oA == oB && sa == sb) begin
      bFirst = rrMod[oA];
      rrMod[oA] = !rrMod[oA];
    end else begin
      bFirst = (sb < sa);
    end
    if (!bFirst) begin
      if (oA >= 0) pushPkt(1'b0, na, oA);
      if (oB >= 0) pushPkt(1'b1, nb, oB);
    end else begin
      if (oB >= 0) pushPkt(1'b1, nb, oB);
      if (oA >= 0) pushPkt(1'b0, na, oA);
    end
    last = (sa + na > sb + nb) ? sa + na : sb + nb;
    for (int i = 0; i < last; i++) begin
      @(negedge clk);
      k = i - sa;
      if (k >= 0 && k < na) begin
        inDataA = pktA[k]; inSopA = (k == 0) || (k == midSopA); inEopA = (k == na - 1);
        if (k == 0) sentA = cyc + 1;
      end else begin
        inDataA = '0; inSopA = 1'b0; inEopA = 1'b0;
      end
      k = i - sb;
      if (k >= 0 && k < nb) begin
        inDataB = pktB[k]; inSopB = (k == 0); inEopB = (k == nb - 1);
        if (k == 0) sentB = cyc + 1;
      end else begin
        inDataB = '0; inSopB = 1'b0; inEopB = 1'b0;
      end
    end
    @(negedge clk);
    zeroInputs();
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (expA_q.size() == 0 && expB_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", 64'(expA_q.size() + expB_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chkIdle(input string name);
    chk({name, "_outA"}, {30'd0, outSopA, outEopA, outDataA}, 64'd0);
    chk({name, "_outB"}, {30'd0, outSopB, outEopB, outDataB}, 64'd0);
    chk({name, "_stall"}, {62'd0, portAStall, portBStall}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    zeroInputs();
    repeat (3) @(negedge clk);
    chkIdle("reset");
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Single 4-word packet A->A, latency 2
    pktA[0] = DA_A; pktA[1] = 32'hD1D1_0001; pktA[2] = 32'hD2D2_0002; pktA[3] = 32'hD3D3_0003;
    drive2(4, 0, 0, 0);
    waitDrain(40);
    chk("lat_AA", 64'(sopCycA - sentA), 64'd2);

    // Cross traffic A->B and B->A concurrently
    pktA[0] = DA_B; pktA[1] = 32'hA0B0_0001; pktA[2] = 32'hA0B0_0002; pktA[3] = 32'hA0B0_0003;
    pktB[0] = DA_A; pktB[1] = 32'hB0A0_0001; pktB[2] = 32'hB0A0_0002; pktB[3] = 32'hB0A0_0003;
    drive2(4, 4, 0, 0);
    waitDrain(40);
    chk("lat_cross_B", 64'(sopCycB - sentA), 64'd2);
    chk("lat_cross_A", 64'(sopCycA - sentB), 64'd2);

    // Contention on output A: A wins first, B follows back to back
    pktA[0] = DA_A; pktA[1] = 32'h1111_0001; pktA[2] = 32'h1111_0002;
    pktB[0] = DA_A; pktB[1] = 32'h2222_0001; pktB[2] = 32'h2222_0002;
    drive2(3, 3, 0, 0);
    waitDrain(40);
    chk("rr_contig", 64'(sopCycA - sentA), 64'd5);

    // Second contention on output A: B wins this time
    pktA[1] = 32'h3333_0001; pktA[2] = 32'h3333_0002;
    pktB[1] = 32'h4444_0001; pktB[2] = 32'h4444_0002;
    drive2(3, 3, 0, 0);
    waitDrain(40);
    chk("rr_second", 64'(sopCycA - sentA), 64'd5);

    // Unknown DA is discarded; following packet forwarded with normal latency
    pktA[0] = 32'h0000_1234; pktA[1] = 32'h5555_0001; pktA[2] = 32'h5555_0002;
    drive2(3, 0, 0, 0);
    repeat (6) @(negedge clk);
    pktA[0] = DA_B; pktA[1] = 32'h6666_0001;
    drive2(2, 0, 0, 0);
    waitDrain(40);
    chk("lat_after_drop", 64'(sopCycB - sentA), 64'd2);

    // One-word packet on B and a packet with a stray SOP in the middle on A
    pktB[0] = DA_B;
    pktA[0] = DA_A; pktA[1] = 32'h7777_0001; pktA[2] = 32'h7777_0002;
    pktA[3] = 32'h7777_0003; pktA[4] = 32'h7777_0004;
    midSopA = 2;
    drive2(5, 1, 0, 0);
    midSopA = -1;
    waitDrain(40);

    // Output A blocked by a 20-word B packet while A queues 16 words
    pktB[0] = DA_A;
    for (int i = 1; i < 20; i++) pktB[i] = 32'hBB00_0000 + 32'(i);
    pktA[0] = DA_A;
    for (int i = 1; i < 16; i++) pktA[i] = 32'hAA00_0000 + 32'(i);
    fork
      drive2(16, 20, 1, 0);
      begin
        repeat (13) @(negedge clk);
        chk("stall_11", {63'd0, portAStall}, 64'd0);
        @(negedge clk);
        chk("stall_12", {63'd0, portAStall}, 64'd1);
        repeat (7) @(negedge clk);
        chk("stall_16", {63'd0, portAStall}, 64'd1);
        repeat (6) @(negedge clk);
        chk("stall_drain12", {63'd0, portAStall}, 64'd1);
        @(negedge clk);
        chk("stall_drain11", {63'd0, portAStall}, 64'd0);
        chk("stallB_low", {63'd0, portBStall}, 64'd0);
      end
    join
    waitDrain(80);

    // Reset mid-packet: only the first word escapes before reset
    pktA[0] = DA_A; pktA[1] = 32'hC0DE_0001; pktA[2] = 32'hC0DE_0002; pktA[3] = 32'hC0DE_0003;
    expA_q.push_back({1'b1, 1'b0, DA_A});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      inDataA = pktA[k]; inSopA = (k == 0); inEopA = 1'b0;
    end
    @(posedge clk);
    #2;
    resetN = 1'b0;
    zeroInputs();
    #1;
    chkIdle("async_reset");
    chk("reset_inflight", 64'(expA_q.size()), 64'd0);
    expA_q.delete();
    expB_q.delete();
    rrMod[0] = 1'b0;
    rrMod[1] = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      inDataA = 32'hDEAD_0000 + 32'(k); inSopA = 1'b0; inEopA = (k == 2);
    end
    @(negedge clk);
    zeroInputs();
    repeat (6) @(negedge clk);
    chkIdle("post_reset_nosop");
    pktA[0] = DA_A; pktA[1] = 32'hF00D_0001; pktA[2] = 32'hF00D_0002;
    drive2(3, 0, 0, 0);
    waitDrain(40);
    chk("lat_post_reset", 64'(sopCycA - sentA), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
